// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter for a shared synchronous single-port memory
module mem_arbiter #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic          MEM_CS,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          busy
);
  logic          last_q, last_d;
  logic          cs_q, cs_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rd1_v_q, rd1_v_d, rd1_id_q, rd2_v_q, rd2_id_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          rvalid0_q, rvalid1_q;

  // Grant: a lone requester wins; on a tie the master that did not win last time wins
  always_comb begin
    m0_gnt = RST & m0_req & (~m1_req | last_q);
    m1_gnt = RST & m1_req & (~m0_req | ~last_q);
  end

  // Next state of the issue stage, read tracker and round-robin pointer
  always_comb begin
    cs_d    = m0_gnt | m1_gnt;
    last_d  = cs_d ? m1_gnt : last_q;
    we_d    = cs_d & (m1_gnt ? m1_we : m0_we);
    addr_d  = cs_d ? (m1_gnt ? m1_addr : m0_addr) : addr_q;
    wdata_d = cs_d ? (m1_gnt ? m1_wdata : m0_wdata) : wdata_q;
    rd1_v_d = cs_d & ~we_d;
  end

  // Issue stage register and two-stage {valid, id} read tracker
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_q   <= 1'b1;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd1_v_q  <= 1'b0;
      rd1_id_q <= 1'b0;
      rd2_v_q  <= 1'b0;
      rd2_id_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd1_v_q  <= rd1_v_d;
      rd1_id_q <= m1_gnt;
      rd2_v_q  <= rd1_v_q;
      rd2_id_q <= rd1_id_q;
    end
  end

  // Read return: capture memory data into the owning master's register and pulse its rvalid
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= rd2_v_q & ~rd2_id_q;
      rvalid1_q <= rd2_v_q & rd2_id_q;
      if (rd2_v_q & ~rd2_id_q) rdata0_q <= MEM_RDATA;
      if (rd2_v_q & rd2_id_q) rdata1_q <= MEM_RDATA;
    end
  end

  assign MEM_CS    = cs_q;
  assign MEM_WE    = we_q;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign busy      = cs_q | rd1_v_q | rd2_v_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grants, issue timing and read return for mem_arbiter
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [6:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        MEM_CS, MEM_WE, busy;
  logic [6:0]  MEM_ADDR;
  logic [31:0] MEM_WDATA, MEM_RDATA;
  logic [31:0] mem [128];
  int          n_chk = 0, n_pass = 0;

  mem_arbiter #(.AW(7), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // synchronous single-port memory model
  always @(posedge CLK) begin
    if (MEM_CS) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
      MEM_RDATA <= mem[MEM_ADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int g0, g1, j;
    logic [6:0] ea;
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + i;
    mem[5] = 32'hDEAD_BEEF;
    mem[1] = 32'h0000_0111;
    mem[2] = 32'h0000_0222;
    mem[3] = 32'h0000_0333;
    MEM_RDATA = '0;
    // reset state
    step(); step();
    check("rst_cs", {31'b0, MEM_CS}, 0);
    check("rst_addr", {25'b0, MEM_ADDR}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rdata0", m0_rdata, 0);
    RST = 1'b1;
    // single m0 read of 0x05
    m0_req = 1; m0_we = 0; m0_addr = 7'h05; #1;
    check("t1_gnt", {30'b0, m0_gnt, m1_gnt}, 32'b10);
    step(); m0_req = 0; #1;
    check("t1_cs_we", {30'b0, MEM_CS, MEM_WE}, 32'b10);
    check("t1_addr", {25'b0, MEM_ADDR}, 32'h05);
    check("t1_busy", {31'b0, busy}, 1);
    step();
    check("t1_rv_early", {31'b0, m0_rvalid}, 0);
    step();
    check("t1_rv", {30'b0, m0_rvalid, m1_rvalid}, 32'b10);
    check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    step();
    check("t1_rv_pulse", {31'b0, m0_rvalid}, 0);
    // m1 write 0x7F then m0 read 0x7F
    m1_req = 1; m1_we = 1; m1_addr = 7'h7F; m1_wdata = 32'h1234_5678; #1;
    check("t2_gnt_w", {30'b0, m0_gnt, m1_gnt}, 32'b01);
    step(); m1_req = 0; m0_req = 1; m0_we = 0; m0_addr = 7'h7F; #1;
    check("t2_we1", {31'b0, MEM_WE}, 1);
    check("t2_gnt_r", {30'b0, m0_gnt, m1_gnt}, 32'b10);
    step(); m0_req = 0; #1;
    check("t2_we0", {30'b0, MEM_CS, MEM_WE}, 32'b10);
    step();
    check("t2_no_m1rv", {31'b0, m1_rvalid}, 0);
    step();
    check("t2_rv", {30'b0, m0_rvalid, m1_rvalid}, 32'b10);
    check("t2_rdata", m0_rdata, 32'h1234_5678);
    // continuous contention from reset release
    RST = 0; step(); step(); RST = 1;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 11; i++) begin
      m0_req = (i < 8); m1_req = (i < 8); m0_we = 0; m1_we = 0;
      m0_addr = 7'(16 + i); m1_addr = 7'(32 + i); #1;
      if (i < 8) begin
        check($sformatf("t3_gnt%0d", i), {30'b0, m0_gnt, m1_gnt}, (i % 2 == 0) ? 32'b10 : 32'b01);
        g0 += int'(m0_gnt); g1 += int'(m1_gnt);
      end
      if (i >= 3) begin
        j = (i - 3) % 2;
        ea = 7'((j == 1) ? 32 + i - 3 : 16 + i - 3);
        check($sformatf("t3_rv%0d", i), {30'b0, m0_rvalid, m1_rvalid}, (j == 0) ? 32'b10 : 32'b01);
        check($sformatf("t3_rd%0d", i), (j == 0) ? m0_rdata : m1_rdata, 32'hA000_0000 + 32'(ea));
      end
      step();
    end
    check("t3_cnt0", g0, 4);
    check("t3_cnt1", g1, 4);
    // m0 back-to-back reads 1,2,3
    for (int i = 0; i < 7; i++) begin
      m0_req = (i < 3); m1_req = 0; m0_we = 0; m0_addr = 7'(i + 1); #1;
      if (i >= 1 && i <= 3) check($sformatf("t4_addr%0d", i), {25'b0, MEM_ADDR}, i);
      if (i >= 3 && i <= 5) begin
        check($sformatf("t4_rv%0d", i), {31'b0, m0_rvalid}, 1);
        check($sformatf("t4_rd%0d", i), m0_rdata, 32'h111 * (i - 2));
      end
      step();
    end
    // m1 alone, then a tie goes to m0, then to m1
    m1_req = 1; m1_we = 1; m1_addr = 7'h40; #1;
    check("t5_m1_alone", {30'b0, m0_gnt, m1_gnt}, 32'b01);
    step(); m0_req = 1; m0_we = 1; m0_addr = 7'h41; #1;
    check("t5_tie_m0", {30'b0, m0_gnt, m1_gnt}, 32'b10);
    step(); #1;
    check("t5_tie_m1", {30'b0, m0_gnt, m1_gnt}, 32'b01);
    step(); m0_req = 0; m1_req = 0; step(); step(); step();
    // reset during an in-flight read
    m0_req = 1; m0_we = 0; m0_addr = 7'h05; #1;
    check("t6_gnt", {31'b0, m0_gnt}, 1);
    step(); RST = 0; #1;
    check("t6_rst_out", {28'b0, MEM_CS, busy, m0_gnt, m0_rvalid}, 0);
    check("t6_rst_rdata", m0_rdata, 0);
    step(); step(); RST = 1;
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1; #1;
    check("t6_tie_m0", {30'b0, m0_gnt, m1_gnt}, 32'b10);
    step(); m0_req = 0; m1_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t6_no_rv%0d", i), {30'b0, m0_rvalid, m1_rvalid}, 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-port 128×32 instruction/data memory between the MIPS core (master 0) and a second requester such as a program loader or debug port (master 1). Each master uses a valid/ready request handshake. The arbiter grants at most one access per cycle using round-robin priority, drives the memory command from a register, and returns read data to the master that issued the read. It sits between the core's memory interface and the memory array, replacing the core's direct CS/WE/ADDR/Mem_Bus connection.

## Interface
- AW, 7, memory word-address width
- DW, 32, data width
- CLK  in  1  system clock; all state updates on rising edge
- RST  in  1  reset, asynchronous, active-low (0 = reset)
- m0_req  in  1  master 0 request valid; held with fields until accepted
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  AW  master 0 word address
- m0_wdata  in  DW  master 0 write data
- m0_gnt  out  1  master 0 request accepted this cycle (combinational)
- m0_rdata  out  DW  master 0 read data, held until next master-0 read completes
- m0_rvalid  out  1  one-cycle pulse: m0_rdata updated
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rdata, m1_rvalid  same as master 0, for master 1
- MEM_CS  out  1  memory chip select (registered)
- MEM_WE  out  1  memory write enable (registered)
- MEM_ADDR  out  AW  memory address (registered)
- MEM_WDATA  out  DW  memory write data (registered)
- MEM_RDATA  in  DW  memory read data; synchronous memory, valid the cycle after the command
- busy  out  1  access issued or read in flight

## Operation
- Handshake: a transfer occurs on a rising edge where mX_req=1 and mX_gnt=1. The master may change or drop req and its fields in the cycle after acceptance. A master must not drop req before it is accepted.
- Grant logic is combinational from req and the last-grant pointer `last`:
  - Only one master requesting: that master is granted.
  - Both requesting: the master with index ≠ `last` is granted.
  - Neither requesting: no grant.
  - m0_gnt and m1_gnt are never 1 together.
- On acceptance, `last` ← granted index. `last` is unchanged otherwise.
- Issue stage: registers MEM_CS=1 and MEM_WE/MEM_ADDR/MEM_WDATA from the accepted master. With no acceptance, MEM_CS=0, MEM_WE=0, and the other fields hold their previous values.
- Read return pipeline: two stages tracking {valid, master id} for reads only.
  - At the edge ending the cycle after issue, MEM_RDATA is captured into the owning master's rdata register, and that master's rvalid pulses for one cycle.
  - The other master's rdata holds its value.
- Writes produce no rvalid.
- Back-to-back acceptances, including alternating masters and mixed read/write, are allowed every cycle with no bubble.
- Returns are in issue order. Each master's reads return in its own request order.
- busy = MEM_CS OR any return-pipeline stage valid.
- Reset (RST=0), applied asynchronously, forces:
  - MEM_CS, MEM_WE, MEM_ADDR, MEM_WDATA = 0
  - m0/m1_rdata = 0, m0/m1_rvalid = 0
  - return pipeline cleared
  - `last` = 1, so master 0 wins the first tie
- Asserting reset mid-operation discards in-flight reads. No rvalid appears for them after reset is released.
- Grants are suppressed while RST=0.

## Timing
- Accept at edge ending cycle T → memory command visible in T+1 → MEM_RDATA valid in T+2 → rvalid=1 and rdata valid in T+3 (read latency: 3 cycles from acceptance).
- Write is committed by memory at the edge ending T+1.
- Throughput: one access per cycle total.
- Under continuous contention each master receives every other cycle.
- Worst-case wait for a requesting master is 1 cycle.
- Read-after-write to the same address from either master, issued in consecutive cycles, returns the new data; memory is serial.
- Simultaneous requests in the first cycle after reset release: master 0 is granted.

## Test plan
- Preload mem[0x05]=0xDEADBEEF; m0 read 0x05 alone → m0_gnt=1 in the request cycle; next cycle MEM_CS=1, MEM_WE=0, MEM_ADDR=0x05; m0_rvalid=1 with m0_rdata=0xDEADBEEF 3 cycles after acceptance; m1_rvalid stays 0.
- m1 write 0x7F ← 0x12345678, then m0 read 0x7F the next cycle → MEM_WE=1 for exactly one cycle, no m1_rvalid; m0_rdata=0x12345678.
- Both masters request reads continuously from reset release for 8 cycles → grants m0,m1,m0,m1,…, 4 each; rvalids alternate with data matching the addresses; never two gnts in one cycle.
- m0 back-to-back reads 0x01,0x02,0x03 → MEM_ADDR=1,2,3 on consecutive cycles; m0_rvalid high for 3 consecutive cycles with mem[1..3] in order.
- m1 granted alone, then both request → m0 granted first (last=1); after that, m1 is granted.
- Read accepted, RST pulled low during the following cycle → all outputs 0 immediately (asynchronous); no rvalid after release; the first tie after release grants m0.
